// File: rtl/dsram_pkg.sv
// Shared constants for the CPU data-SRAM responder: MMIO offsets, STATUS bit
// positions and register reset values.
package dsram_pkg;

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_CMP    = 16'he004;
    localparam logic [15:0] OFF_STATUS = 16'he008;

    localparam int ST_IRQ = 0;
    localparam int ST_ERR = 1;

    localparam logic [31:0] CMP_RST   = 32'hffffffff;
    localparam logic [31:0] TIMER_RST = 32'h0;

endpackage

// File: rtl/dsram_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
module dsram_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM port responder: RAM plus LED / TIMER / CMP / STATUS register window.
// Timer and compare logic are built only when DSRAM_TIMER_EN is defined.
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter int          LED_W   = 16,
    parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_sram_we,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    logic        is_mmio, aligned, wr_ok;
    logic [15:0] off;
    logic        ram_we, wr_led, wr_status, err_set;
    logic [31:0] ram_rd, mmio_rd, timer_rd, cmp_rd;
    logic        irq_st;

    logic [LED_W-1:0] led_q, led_d;
    logic             err_q, err_d;

    // Low address bits are ignored for register selection; misaligned stores never commit.
    assign is_mmio = (data_sram_addr[31:16] == MMIO_HI);
    assign aligned = (data_sram_addr[1:0] == 2'b00);
    assign off     = {data_sram_addr[15:2], 2'b00};
    assign wr_ok   = data_sram_we & ~reset & aligned;
    assign err_set = data_sram_we & ~reset & ~aligned;

    assign ram_we    = wr_ok & ~is_mmio;
    assign wr_led    = wr_ok & is_mmio & (off == OFF_LED);
    assign wr_status = wr_ok & is_mmio & (off == OFF_STATUS);

    dsram_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (data_sram_addr[ADDR_W+1:2]),
        .wdata_i (data_sram_wdata),
        .rdata_o (ram_rd)
    );

    always_comb begin
        led_d = led_q;
        if (wr_led) begin
            led_d = data_sram_wdata[LED_W-1:0];
        end
        // A fresh error outranks a W1C clear in the same cycle.
        err_d = err_q;
        if (wr_status && data_sram_wdata[ST_ERR]) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
            err_q <= 1'b0;
        end else begin
            led_q <= led_d;
            err_q <= err_d;
        end
    end

`ifdef DSRAM_TIMER_EN
    logic        wr_timer, wr_cmp;
    logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
    logic        irq_q, irq_d;

    assign wr_timer = wr_ok & is_mmio & (off == OFF_TIMER);
    assign wr_cmp   = wr_ok & is_mmio & (off == OFF_CMP);

    always_comb begin
        timer_d = wr_timer ? data_sram_wdata : timer_q + 32'd1;
        cmp_d   = wr_cmp ? data_sram_wdata : cmp_q;
        irq_d   = irq_q;
        if (wr_status && data_sram_wdata[ST_IRQ]) begin
            irq_d = 1'b0;
        end
        if (timer_q == cmp_q) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= TIMER_RST;
            cmp_q   <= CMP_RST;
            irq_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    assign timer_rd = timer_q;
    assign cmp_rd   = cmp_q;
    assign irq_st   = irq_q;
`else
    assign timer_rd = '0;
    assign cmp_rd   = '0;
    assign irq_st   = 1'b0;
`endif

    always_comb begin
        mmio_rd = '0;
        case (off)
            OFF_LED:    mmio_rd[LED_W-1:0] = led_q;
            OFF_TIMER:  mmio_rd = timer_rd;
            OFF_CMP:    mmio_rd = cmp_rd;
            OFF_STATUS: begin
                mmio_rd[ST_IRQ] = irq_st;
                mmio_rd[ST_ERR] = err_q;
            end
            default:    mmio_rd = '0;
        endcase
    end

    assign data_sram_rdata = is_mmio ? mmio_rd : ram_rd;
    assign led             = led_q;
    assign irq             = irq_st;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder; driver queues expectations, negedge monitor checks them.
module tb_dsram_responder;

`ifdef DSRAM_TIMER_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    localparam int NO = -1;
    localparam int KR = 0;
    localparam int KL = 1;
    localparam int KI = 2;

    localparam logic [31:0] A_LED    = 32'hbfaff000;
    localparam logic [31:0] A_TIMER  = 32'hbfafe000;
    localparam logic [31:0] A_CMP    = 32'hbfafe004;
    localparam logic [31:0] A_STATUS = 32'hbfafe008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    bit   chk_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dsram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the edge; optionally queue an expectation for it.
    task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int kind, input logic [31:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        we      = w;
        addr    = a;
        wdata   = d;
        chk_req = (kind >= 0);
        if (kind >= 0) begin
            x.kind = kind;
            x.exp  = e;
            x.name = nm;
            sb.push_back(x);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t        x;
        logic [31:0] act;
        if (chk_req) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: monitor had no expectation queued");
            end else begin
                x = sb.pop_front();
                case (x.kind)
                    KR:      act = rdata;
                    KL:      act = {16'h0, led};
                    default: act = {31'h0, irq};
                endcase
                if (act !== x.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
                end
            end
        end
    end

    initial begin
        // Reset phase: writes ignored, reset values visible.
        cyc(1, A_LED, 32'hffff, KL, 32'h0, "led_in_reset");
        cyc(1, A_LED, 32'hffff, KL, 32'h0, "led_hold_reset");
        cyc(0, A_CMP, 0, KR, TEN ? 32'hffffffff : 32'h0, "cmp_rst");
        cyc(0, A_TIMER, 0, KR, 32'h0, "timer_rst");
        cyc(0, A_STATUS, 0, KR, 32'h0, "status_rst");
        cyc(0, A_STATUS, 0, KI, 32'h0, "irq_rst");
        reset = 1'b0;

        // RAM write/read, aliasing and read-during-write.
        cyc(1, 32'h1c000014, 32'h0, NO, 0, "");
        cyc(1, 32'h1c000010, 32'h12345678, NO, 0, "");
        cyc(0, 32'h1c000010, 0, KR, 32'h12345678, "ram_rd");
        cyc(0, 32'h1c000014, 0, KR, 32'h0, "ram_next_word");
        cyc(0, 32'h1c001010, 0, KR, 32'h12345678, "ram_alias");
        cyc(1, 32'h1c000010, 32'h55aa55aa, KR, 32'h12345678, "rdw_old");
        cyc(0, 32'h1c000010, 0, KR, 32'h55aa55aa, "rdw_new");

        // Misaligned store is dropped and flags ERR; W1C clears it.
        cyc(1, 32'h1c000012, 32'hdeadbeef, NO, 0, "");
        cyc(0, 32'h1c000010, 0, KR, 32'h55aa55aa, "misalign_nowrite");
        cyc(0, A_STATUS, 0, KR, 32'h2, "err_set");
        cyc(0, 32'h1c000013, 0, KR, 32'h55aa55aa, "rd_ignores_lsb");
        cyc(1, A_STATUS, 32'h2, NO, 0, "");
        cyc(0, A_STATUS, 0, KR, 32'h0, "err_w1c");

        // LED register and unmapped offset.
        cyc(1, A_LED, 32'h0000a5a5, NO, 0, "");
        cyc(0, A_LED, 0, KL, 32'h0000a5a5, "led_out");
        cyc(0, A_LED, 0, KR, 32'h0000a5a5, "led_rd");
        cyc(1, A_LED, 32'hffffffff, NO, 0, "");
        cyc(0, A_LED, 0, KR, 32'h0000ffff, "led_upper0");
        cyc(1, 32'hbfaf1230, 32'hffffffff, NO, 0, "");
        cyc(0, 32'hbfaf1230, 0, KR, 32'h0, "unmapped");

        // Timer compare: IRQ rises six cycles after the TIMER write.
        cyc(1, A_TIMER, 32'h0, NO, 0, "");
        cyc(1, A_CMP, 32'h5, KR, TEN ? 32'hffffffff : 32'h0, "cmp_old");
        for (int i = 1; i <= 6; i++) begin
            cyc(0, A_TIMER, 0, KI, (TEN && i == 6) ? 32'h1 : 32'h0, "irq_rise");
        end
        cyc(1, A_STATUS, 32'h1, KI, TEN ? 32'h1 : 32'h0, "irq_before_clr");
        cyc(0, A_STATUS, 0, KI, 32'h0, "irq_clr");
        cyc(0, A_CMP, 0, KR, TEN ? 32'h5 : 32'h0, "cmp_rd");

        // Wrap from all-ones to zero raises nothing.
        cyc(1, A_TIMER, 32'hfffffffe, NO, 0, "");
        cyc(0, A_TIMER, 0, KR, TEN ? 32'hfffffffe : 32'h0, "tmr_load");
        cyc(0, A_TIMER, 0, KR, TEN ? 32'hffffffff : 32'h0, "tmr_inc");
        cyc(0, A_TIMER, 0, KR, 32'h0, "tmr_wrap");
        cyc(0, A_STATUS, 0, KR, 32'h0, "no_irq_wrap");

        @(posedge clk);
        #1;
        we      = 1'b0;
        chk_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
# dsram_responder

Responder side of the CPU data-SRAM port: accepts the single-cycle `data_sram_*` requests issued by the CPU core and returns read data. It combines a word-addressed data RAM with a small memory-mapped register window: LED register, free-running timer with compare, and sticky status flags. It sits beside the core in the SoC top, wired directly to the core's `data_sram_we/addr/wdata/rdata`.

## Interface
- `ADDR_W`, 10, log2 of RAM depth in 32-bit words.
- `LED_W`, 16, width of LED register and `led` output.
- `MMIO_HI`, 16'hbfaf, value of `addr[31:16]` that selects the register window.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; sampled on `clk`.
- `data_sram_we` input 1: write strobe for the current cycle.
- `data_sram_addr` input 32: byte address.
- `data_sram_wdata` input 32: write data.
- `data_sram_rdata` output 32: read data for `data_sram_addr`, combinational.
- `led` output LED_W: LED register contents.
- `irq` output 1: timer-compare flag (STATUS bit0).

## Operation
- Region decode:
  - MMIO when `addr[31:16]==MMIO_HI`.
  - Otherwise RAM at word index `addr[ADDR_W+1:2]`; upper bits are aliased (ignored).
- Misaligned access (`addr[1:0]!=0`) with `we=1`:
  - the write is dropped;
  - STATUS bit1 (ERR) is set.
  - Reads ignore `addr[1:0]`.
- MMIO offsets (`addr[15:0]`):
  - 0xf000 LED: R/W, low LED_W bits, upper bits read 0.
  - 0xe000 TIMER: R/W 32-bit. Increments by 1 every cycle. A write loads `wdata` and suppresses that cycle's increment.
  - 0xe004 CMP: R/W 32-bit.
  - 0xe008 STATUS: bit0 IRQ, bit1 ERR, other bits read 0. Writing 1 to a bit clears it (W1C); writing 0 has no effect.
  - Any other offset reads 0; writes to it are ignored.
- IRQ is set in the cycle after TIMER equals CMP, and stays set until cleared by a W1C write.
- Simultaneous set and W1C clear of the same bit: set wins.
- RAM contents are not cleared by reset.
- While `reset=1`, all writes (RAM and MMIO) are ignored. This covers stores the core decodes before its `valid` rises.

## Timing
- Read latency is 0: `data_sram_rdata` is a combinational function of `addr` and current state.
- A write takes effect at the rising edge that samples `we=1`.
- Read-during-write to the same address returns the old value in that cycle and the new value from the next cycle.
- Back-to-back writes are accepted every cycle; there is no stall and no handshake.
- Reset values:
  - `led`=0, `irq`=0;
  - TIMER=0, CMP=32'hffffffff, STATUS=0;
  - `data_sram_rdata` reflects these values (RAM reads return its uninitialised contents).
- TIMER wraps from 32'hffffffff to 0 without setting any flag.
- Compare is evaluated against the registered TIMER value. When a write loads TIMER==CMP, IRQ is set one cycle later.

## Configuration
- `DSRAM_TIMER_EN` defined:
  - TIMER, CMP and STATUS.IRQ are implemented as described.
- `DSRAM_TIMER_EN` undefined:
  - no timer or compare logic is built;
  - offsets 0xe000 and 0xe004 read 0 and ignore writes;
  - STATUS bit0 reads 0 and `irq` is tied 0;
  - LED, RAM and ERR are unchanged.

## Structure
- Shared package `dsram_pkg`:
  - MMIO offset constants `OFF_LED`, `OFF_TIMER`, `OFF_CMP`, `OFF_STATUS`;
  - STATUS bit indices `ST_IRQ`, `ST_ERR`;
  - reset constants `CMP_RST`, `TIMER_RST`.
- One sub-module, `dsram_ram`: 2^ADDR_W × 32 array with asynchronous read and synchronous write.
- Decode, MMIO registers and the read mux stay in the top of this block.

## Test plan
- Reset, then write 32'h12345678 to 0x1c000010, then read 0x1c000010 → returns 32'h12345678. Reading 0x1c000014 does not return it.
- Write 32'h0000a5a5 to 0xbfaff000 → `led`=16'ha5a5 from the next cycle. Reading it back returns 32'h0000a5a5.
- Write 0 to TIMER, write 5 to CMP in the following cycle, then idle → `irq` rises 6 cycles after the TIMER write. Write 32'h1 to 0xbfafe008 → `irq`=0 on the next cycle.
- Write 32'hdeadbeef to 0x1c000012 (misaligned) → the RAM word at 0x1c000010 is unchanged and STATUS reads 32'h2.
- Hold `reset`=1 with `we`=1 to 0xbfaff000 (wdata 32'hffff) → `led` stays 0. Reset values hold: CMP reads 32'hffffffff, TIMER reads 0.
- Load TIMER with 32'hfffffffe → reads 32'hffffffff, then 0, on the next two cycles; `irq` stays 0 (CMP at its reset value is passed without IRQ only when CMP has been set to a distinct value first). Build without `DSRAM_TIMER_EN` → TIMER reads 0 and `irq` stays 0.
